// File: rtl/matrix_pkg.sv
// ============================================================================
// matrix_pkg: shared geometry, sequencer states and ALU op codes. Rev 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

  localparam int MATRIX_DIM       = 10;
  localparam int ELEM_W           = 2;
  localparam int MATRIX_W         = MATRIX_DIM * MATRIX_DIM * ELEM_W;
  localparam int WORD_W           = 8;
  localparam int WORDS_PER_MATRIX = MATRIX_W / WORD_W;
  localparam int IDX_W            = $clog2(WORDS_PER_MATRIX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    DRAIN  = 3'd5
  } seq_state_e;

  localparam logic [3:0] OP_ADD       = 4'd0;
  localparam logic [3:0] OP_SUB       = 4'd1;
  localparam logic [3:0] OP_MUL       = 4'd2;
  localparam logic [3:0] OP_HADAMARD  = 4'd3;
  localparam logic [3:0] OP_TRANSPOSE = 4'd4;
  localparam logic [3:0] OP_NEGATE    = 4'd5;

  function automatic logic is_last_word(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(WORDS_PER_MATRIX - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_word_buffer.sv
// ============================================================================
// matrix_word_buffer: 200-bit register, indexed word write/read, parallel load. Rev 1.0
// ============================================================================
`default_nettype none

module matrix_word_buffer
  import matrix_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [WORD_W-1:0]   wr_data_i,
  input  logic                ld_en_i,
  input  logic [MATRIX_W-1:0] ld_data_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [WORD_W-1:0]   rd_data_o,
  output logic [MATRIX_W-1:0] data_o
);

  logic [MATRIX_W-1:0] data_q;

  // Parallel load wins over a word write; the sequencer never asserts both.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (ld_en_i) begin
      data_q <= ld_data_i;
    end else if (wr_en_i) begin
      data_q[int'(wr_idx_i) * WORD_W +: WORD_W] <= wr_data_i;
    end
  end

  assign rd_data_o = data_q[int'(rd_idx_i) * WORD_W +: WORD_W];
  assign data_o    = data_q;

endmodule

`default_nettype wire

// File: rtl/matrix_sequencer.sv
// ============================================================================
// matrix_sequencer: streams A/B into the matrix ALU and drains C as bytes. Rev 1.0
// Optional WAIT watchdog enabled by defining MATRIX_SEQ_TIMEOUT_EN.
// ============================================================================
`default_nettype none

module matrix_sequencer
  import matrix_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  output logic                alu_start,
  output logic [3:0]          alu_op_code,
  output logic [MATRIX_W-1:0] alu_matrix_a,
  output logic [MATRIX_W-1:0] alu_matrix_b,
  input  logic                alu_done,
  input  logic [MATRIX_W-1:0] alu_matrix_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                busy,
  output logic                error
);

  seq_state_e       state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic             alu_start_q;

  logic cmd_fire_d;
  logic in_fire_d;
  logic out_fire_d;
  logic last_word_d;
  logic wd_expire_d;

  logic [WORD_W-1:0]   unused_a_rd;
  logic [WORD_W-1:0]   unused_b_rd;
  logic [MATRIX_W-1:0] unused_c_par;

  // Handshake readiness is masked by reset so nothing transfers while held.
  assign cmd_ready = reset_n && (state_q == IDLE);
  assign in_ready  = reset_n && ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign out_valid = reset_n && (state_q == DRAIN);
  assign busy      = (state_q != IDLE);

  assign cmd_fire_d  = cmd_valid && cmd_ready;
  assign in_fire_d   = in_valid && in_ready;
  assign out_fire_d  = out_valid && out_ready;
  assign last_word_d = is_last_word(cnt_q);

  assign alu_start   = alu_start_q;
  assign alu_op_code = op_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      alu_start_q <= 1'b0;
    end else begin
      alu_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_fire_d) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            op_q    <= cmd_op;
          end
        end
        LOAD_A: begin
          if (in_fire_d) begin
            if (last_word_d) begin
              state_q <= LOAD_B;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_fire_d) begin
            if (last_word_d) begin
              state_q     <= START;
              cnt_q       <= '0;
              alu_start_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        START: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: begin
          if (alu_done) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end else if (wd_expire_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          if (out_fire_d) begin
            if (last_word_d) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef MATRIX_SEQ_TIMEOUT_EN
  logic [15:0] wd_cnt_q;
  logic        error_q;

  // wd_cnt_q counts completed WAIT cycles; expiry fires on the last allowed one.
  assign wd_expire_d = (state_q == WAIT) && !alu_done &&
                       (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state_q == START) begin
        wd_cnt_q <= '0;
      end else if (state_q == WAIT) begin
        wd_cnt_q <= wd_cnt_q + 16'd1;
      end
      if (cmd_fire_d) begin
        error_q <= 1'b0;
      end else if (wd_expire_d) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error = error_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wd_expire_d = 1'b0;
  assign error       = 1'b0;
`endif

  matrix_word_buffer u_buf_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en_i   (in_fire_d && (state_q == LOAD_A)),
    .wr_idx_i  (cnt_q),
    .wr_data_i (in_data),
    .ld_en_i   (1'b0),
    .ld_data_i ('0),
    .rd_idx_i  (cnt_q),
    .rd_data_o (unused_a_rd),
    .data_o    (alu_matrix_a)
  );

  matrix_word_buffer u_buf_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en_i   (in_fire_d && (state_q == LOAD_B)),
    .wr_idx_i  (cnt_q),
    .wr_data_i (in_data),
    .ld_en_i   (1'b0),
    .ld_data_i ('0),
    .rd_idx_i  (cnt_q),
    .rd_data_o (unused_b_rd),
    .data_o    (alu_matrix_b)
  );

  matrix_word_buffer u_buf_c (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en_i   (1'b0),
    .wr_idx_i  (cnt_q),
    .wr_data_i ('0),
    .ld_en_i   (alu_done && (state_q == WAIT)),
    .ld_data_i (alu_matrix_c),
    .rd_idx_i  (cnt_q),
    .rd_data_o (out_data),
    .data_o    (unused_c_par)
  );

endmodule

`default_nettype wire
